hash_controller: RTL and testbench
==================================

HASH_CONTROLLER -- requirements
Module: hash_controller

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Port: clock  input  1  rising-edge system clock.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: msg_start  input  1  single-cycle request to begin a new message.
REQ-005 Port: in_valid  input  1  upstream byte valid.
REQ-006 Port: in_ready  output  1  controller can accept a byte.
REQ-007 Port: in_data  input  8  message byte.
REQ-008 Port: in_last  input  1  qualifies in_data as the final byte of the message.
REQ-009 Port: out_valid  output  1  digest on datapath R_h is final.
REQ-010 Port: out_ready  input  1  downstream has consumed the digest.
REQ-011 Port: err  output  1  message overflowed the datapath byte counter; valid while out_valid=1.
REQ-012 Port: dp_start  output  1  datapath start (clears R_c, R_h, R_b).
REQ-013 Port: dp_B  output  8  byte to datapath.
REQ-014 Port: dp_validate_input  output  1  datapath loads dp_B and increments its counter.
REQ-015 Port: dp_switch_operation  output  1  0 = byte rounds (M6 path), 1 = finalisation rounds (C6 path).
REQ-016 Port: dp_validate_R_h  output  1  datapath updates R_h this cycle.
REQ-017 Port: dp_R_i  output  3  round index.
REQ-018 Port: dp_cnt_ok  input  1  datapath case_R_c_zero; 0 when the byte counter is all ones.

Function
REQ-019 States SHALL be IDLE, INIT, WAIT_BYTE, ROUND, FINAL, DONE.
REQ-020 IDLE: all outputs 0; msg_start=1 -> INIT.
REQ-021 INIT: dp_start=1 for exactly one cycle -> WAIT_BYTE.
REQ-022 WAIT_BYTE: in_ready = dp_cnt_ok; dp_B = in_data combinationally; dp_validate_input = in_valid & in_ready.
REQ-023 On accept (in_valid & in_ready): latch in_last, clear the round counter -> ROUND.
REQ-024 WAIT_BYTE with dp_cnt_ok=0: set sticky err, no accept -> FINAL.
REQ-025 ROUND: dp_validate_R_h=1, dp_switch_operation=0, dp_R_i = round counter; counter increments each cycle.
REQ-026 ROUND exit at counter=7: latched last=1 -> FINAL with counter wrapped to 0; last=0 -> WAIT_BYTE.
REQ-027 FINAL: dp_validate_R_h=1, dp_switch_operation=1, dp_R_i = counter 0..7; counter=7 -> DONE.
REQ-028 DONE: out_valid=1, held until out_ready=1, then -> IDLE with err cleared.
REQ-029 Outside ROUND and FINAL, dp_validate_R_h SHALL be 0; dp_R_i SHALL be 0 outside ROUND and FINAL.
REQ-030 in_ready SHALL be 0 in every state except WAIT_BYTE.
REQ-031 msg_start=1 in any state other than IDLE SHALL abort the current message: clear err -> INIT.
REQ-032 The round counter SHALL be 3 bits and wrap 7->0.
REQ-033 Per-byte cost SHALL be 9 cycles (1 accept + 8 rounds); finalisation SHALL be 8 cycles.

Reset
REQ-034 rst=1 SHALL force IDLE, round counter=0, latched last=0, err=0, and all outputs to 0 immediately, including mid-message.
REQ-035 After reset, a message SHALL begin only on a new msg_start.

Structure
REQ-036 A shared package hash_pkg SHALL hold the state enum, NUM_ROUNDS=8, and the round-index width (3).
REQ-037 The FSM and round counter SHALL stay in hash_controller; one sub-module, hash_round_counter (3-bit counter with clear, enable, and a terminal-count flag), is permitted.

Verification
REQ-038 One-byte message 0xA5, in_last=1, accepted at cycle c -> dp_validate_R_h high c+1..c+16; dp_R_i 0..7 twice; dp_switch_operation=1 c+9..c+16; out_valid at c+17.
REQ-039 Three-byte message with in_valid held high -> accepts exactly 9 cycles apart; dp_validate_input high exactly 3 cycles; digest out_valid 17 cycles after the last accept.
REQ-040 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, in_ready 0; out_ready=1 -> IDLE next cycle.
REQ-041 Force dp_cnt_ok=0 in WAIT_BYTE -> in_ready=0, FINAL for 8 cycles, out_valid=1 with err=1.
REQ-042 msg_start during ROUND at dp_R_i=3 -> dp_start pulse next cycle, then WAIT_BYTE; no out_valid for the aborted message.
REQ-043 rst asserted mid-FINAL -> all outputs 0 asynchronously; no out_valid until a new msg_start.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared constants and state encoding for the hash message controller.
package hash_pkg;

  localparam int unsigned NUM_ROUNDS = 8;
  localparam int unsigned RIDX_W     = 3;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned STATE_W    = 3;

  // Controller state encoding
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_INIT      = 3'd1;
  localparam state_t ST_WAIT_BYTE = 3'd2;
  localparam state_t ST_ROUND     = 3'd3;
  localparam state_t ST_FINAL     = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

endpackage

// File: rtl/hash_controller_if.sv
// Message, digest and datapath-control signals between controller and its neighbours.
interface hash_controller_if;
  import hash_pkg::*;

  logic              msg_start;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic              err;
  logic              dp_start;
  logic [BYTE_W-1:0] dp_B;
  logic              dp_validate_input;
  logic              dp_switch_operation;
  logic              dp_validate_R_h;
  logic [RIDX_W-1:0] dp_R_i;
  logic              dp_cnt_ok;

  // Controller side
  modport master (
    input  msg_start, in_valid, in_data, in_last, out_ready, dp_cnt_ok,
    output in_ready, out_valid, err, dp_start, dp_B, dp_validate_input,
           dp_switch_operation, dp_validate_R_h, dp_R_i
  );

  // Upstream / downstream / datapath side
  modport slave (
    output msg_start, in_valid, in_data, in_last, out_ready, dp_cnt_ok,
    input  in_ready, out_valid, err, dp_start, dp_B, dp_validate_input,
           dp_switch_operation, dp_validate_R_h, dp_R_i
  );

endinterface

// File: rtl/hash_round_counter.sv
// Round index counter: clear has priority over enable, wraps at NUM_ROUNDS.
module hash_round_counter
  import hash_pkg::*;
(
  input  logic              clock,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [RIDX_W-1:0] cnt,
  output logic              tc
);

  // Round index register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + RIDX_W'(1);
    end
  end

  assign tc = (cnt == RIDX_W'(NUM_ROUNDS - 1));

endmodule

// File: rtl/hash_controller.sv
// Byte-serial hash controller: sequences datapath byte rounds and finalisation.
module hash_controller
  import hash_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  hash_controller_if.master bus
);

  state_t            state;
  state_t            state_nxt;
  logic              last_q;
  logic              err_q;
  logic [RIDX_W-1:0] rnd;
  logic              rnd_tc;
  logic              rnd_clr;
  logic              rnd_en;
  logic              accept;
  logic              cnt_fail;
  logic              abort;

  hash_round_counter u_round_counter (
    .clock (clock),
    .rst   (rst),
    .clr   (rnd_clr),
    .en    (rnd_en),
    .cnt   (rnd),
    .tc    (rnd_tc)
  );

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_nxt               = state;
    rnd_clr                 = 1'b0;
    rnd_en                  = 1'b0;
    accept                  = 1'b0;
    cnt_fail                = 1'b0;
    abort                   = bus.msg_start && (state != ST_IDLE);
    bus.in_ready            = 1'b0;
    bus.out_valid           = 1'b0;
    bus.err                 = 1'b0;
    bus.dp_start            = 1'b0;
    bus.dp_B                = '0;
    bus.dp_validate_input   = 1'b0;
    bus.dp_switch_operation = 1'b0;
    bus.dp_validate_R_h     = 1'b0;
    bus.dp_R_i              = '0;

    case (state)
      ST_IDLE: begin
        if (bus.msg_start) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        bus.dp_start = 1'b1;
        rnd_clr      = 1'b1;
        state_nxt    = ST_WAIT_BYTE;
      end
      ST_WAIT_BYTE: begin
        bus.in_ready          = bus.dp_cnt_ok;
        bus.dp_B              = bus.in_data;
        accept                = bus.in_valid && bus.dp_cnt_ok;
        bus.dp_validate_input = accept;
        if (!bus.dp_cnt_ok) begin
          // Byte counter saturated: flag overflow and finalise what we have
          cnt_fail  = 1'b1;
          rnd_clr   = 1'b1;
          state_nxt = ST_FINAL;
        end else if (accept) begin
          rnd_clr   = 1'b1;
          state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        bus.dp_validate_R_h = 1'b1;
        bus.dp_R_i          = rnd;
        rnd_en              = 1'b1;
        if (rnd_tc) state_nxt = last_q ? ST_FINAL : ST_WAIT_BYTE;
      end
      ST_FINAL: begin
        bus.dp_validate_R_h     = 1'b1;
        bus.dp_switch_operation = 1'b1;
        bus.dp_R_i              = rnd;
        rnd_en                  = 1'b1;
        if (rnd_tc) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.err       = err_q;
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // A new message request mid-flight restarts from INIT
    if (abort) begin
      state_nxt = ST_INIT;
      rnd_en    = 1'b0;
      rnd_clr   = 1'b1;
    end
  end

  // Last-byte marker and sticky overflow flag
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) last_q <= bus.in_last;
      if (abort || ((state == ST_DONE) && bus.out_ready)) begin
        err_q <= 1'b0;
      end else if (cnt_fail) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hash_controller.sv
// Scoreboard bench for hash_controller: expected datapath events are queued by stimulus.
module tb_hash_controller;
  import hash_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  hash_controller_if bus();

  hash_controller dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int a;
    int b;
  } exp_t;

  exp_t q_start[$];
  exp_t q_acc[$];
  exp_t q_rh[$];
  exp_t q_out[$];

  function automatic exp_t mk(input int c, input int a, input int b);
    exp_t e;
    e.cyc = c;
    e.a   = a;
    e.b   = b;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event with no expectation queued (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.in_ready, bus.out_valid, bus.err, bus.dp_start, bus.dp_B,
                bus.dp_validate_input, bus.dp_switch_operation,
                bus.dp_validate_R_h, bus.dp_R_i});
  endfunction

  // Monitor: pop and compare on every observed DUT event
  logic prev_ov = 1'b0;
  always @(negedge clock) begin : mon
    exp_t e;
    if (rst) begin
      prev_ov <= 1'b0;
    end else begin
      if (bus.dp_start) begin
        if (q_start.size() == 0) unexpected("dp_start");
        else begin
          e = q_start.pop_front();
          check("dp_start_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.dp_validate_input) begin
        if (q_acc.size() == 0) unexpected("accept");
        else begin
          e = q_acc.pop_front();
          check("accept_cycle", 32'(cyc), 32'(e.cyc));
          check("accept_byte", 32'(bus.dp_B), 32'(e.a));
        end
      end
      if (bus.dp_validate_R_h) begin
        if (q_rh.size() == 0) unexpected("validate_R_h");
        else begin
          e = q_rh.pop_front();
          check("round_cycle", 32'(cyc), 32'(e.cyc));
          check("round_index", 32'(bus.dp_R_i), 32'(e.a));
          check("round_switch_op", 32'(bus.dp_switch_operation), 32'(e.b));
        end
      end else begin
        check("ridx_zero_outside_rounds", 32'(bus.dp_R_i), 32'(0));
      end
      if (bus.out_valid && !prev_ov) begin
        if (q_out.size() == 0) unexpected("out_valid");
        else begin
          e = q_out.pop_front();
          check("digest_cycle", 32'(cyc), 32'(e.cyc));
          check("digest_err", 32'(bus.err), 32'(e.a));
        end
      end
      prev_ov <= bus.out_valid;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_rounds(input int first, input int sw);
    for (int i = 0; i < 8; i++) q_rh.push_back(mk(first + i, i, sw));
  endtask

  // Raise msg_start in the current cycle s; returns s, leaves bench in cycle s+1
  task automatic start_msg(output int s);
    bus.msg_start = 1'b1;
    s = cyc;
    q_start.push_back(mk(s + 1, 0, 0));
    tick();
    bus.msg_start = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (bus.out_valid) found = 1'b1;
      else tick();
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout: got none expected within %0d cycles", budget);
    end
  endtask

  task automatic finish_out();
    wait_out(60);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("idle_after_ready", 32'(bus.out_valid), 32'(0));
  endtask

  initial begin
    int s;
    int a;
    int w;
    bus.msg_start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.dp_cnt_ok = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", outs(), 32'(0));
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(bus.in_ready), 32'(0));

    // One-byte message 0xA5, then hold DONE for 5 cycles
    start_msg(s);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    bus.in_last  = 1'b1;
    q_acc.push_back(mk(s + 2, 8'hA5, 0));
    push_rounds(s + 3, 0);
    push_rounds(s + 11, 1);
    q_out.push_back(mk(s + 19, 0, 0));
    tick();
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    wait_out(40);
    for (int k = 0; k < 5; k++) begin
      check("done_hold_valid", 32'(bus.out_valid), 32'(1));
      check("done_hold_in_ready", 32'(bus.in_ready), 32'(0));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("idle_after_ready", 32'(bus.out_valid), 32'(0));

    // Three-byte message with in_valid held high: accepts 9 cycles apart
    tick();
    start_msg(s);
    bus.in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      a = s + 2 + 9 * b;
      bus.in_data = 8'(17 * (b + 1));
      bus.in_last = (b == 2);
      q_acc.push_back(mk(a, 17 * (b + 1), 0));
      push_rounds(a + 1, 0);
      if (b == 2) begin
        push_rounds(a + 9, 1);
        q_out.push_back(mk(a + 17, 0, 0));
      end
      while (cyc < a + 1) tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    finish_out();

    // Byte counter saturated while waiting for a byte
    tick();
    start_msg(s);
    bus.dp_cnt_ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    push_rounds(s + 3, 1);
    q_out.push_back(mk(s + 11, 1, 0));
    tick();
    check("cnt_fail_in_ready", 32'(bus.in_ready), 32'(0));
    check("cnt_fail_no_accept", 32'(bus.dp_validate_input), 32'(0));
    tick();
    bus.dp_cnt_ok = 1'b1;
    bus.in_valid  = 1'b0;
    wait_out(40);
    check("err_in_done", 32'(bus.err), 32'(1));
    finish_out();
    check("err_cleared", 32'(bus.err), 32'(0));

    // Abort during ROUND at index 3
    tick();
    start_msg(s);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    bus.in_last  = 1'b1;
    q_acc.push_back(mk(s + 2, 8'h5A, 0));
    for (int i = 0; i < 4; i++) q_rh.push_back(mk(s + 3 + i, i, 0));
    tick();
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    while (cyc < s + 6) tick();
    check("abort_ridx", 32'(bus.dp_R_i), 32'(3));
    bus.msg_start = 1'b1;
    q_start.push_back(mk(s + 7, 0, 0));
    tick();
    bus.msg_start = 1'b0;
    check("abort_dp_start", 32'(bus.dp_start), 32'(1));
    tick();
    check("abort_wait_byte", 32'(bus.in_ready), 32'(1));
    repeat (20) tick();
    check("abort_no_digest", 32'(bus.out_valid), 32'(0));
    check("abort_still_waiting", 32'(bus.in_ready), 32'(1));
    w = cyc;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    bus.in_last  = 1'b1;
    q_acc.push_back(mk(w, 8'h3C, 0));
    push_rounds(w + 1, 0);
    push_rounds(w + 9, 1);
    q_out.push_back(mk(w + 17, 0, 0));
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    finish_out();

    // Asynchronous reset in the middle of FINAL
    tick();
    start_msg(s);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    bus.in_last  = 1'b1;
    q_acc.push_back(mk(s + 2, 8'hC3, 0));
    push_rounds(s + 3, 0);
    q_rh.push_back(mk(s + 11, 0, 1));
    q_rh.push_back(mk(s + 12, 1, 1));
    tick();
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    while (cyc < s + 13) tick();
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", outs(), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    repeat (25) tick();
    check("post_reset_no_digest", 32'(bus.out_valid), 32'(0));
    check("post_reset_no_rounds", 32'(bus.dp_validate_R_h), 32'(0));

    // Every queued expectation must have been consumed
    check("q_start_drained", 32'(q_start.size()), 32'(0));
    check("q_acc_drained", 32'(q_acc.size()), 32'(0));
    check("q_rh_drained", 32'(q_rh.size()), 32'(0));
    check("q_out_drained", 32'(q_out.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
